// File: rtl/alu_decode_stage_pkg.sv
// Shared encodings for the RV32E decode stage: opcodes, ALU codes, operand selects,
// instruction kinds and the registered control bundle.
package alu_decode_stage_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned REG_BITS = 4;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
  localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_SLL = 4'd2,
    ALU_LT  = 4'd3,
    ALU_LTU = 4'd4,
    ALU_XOR = 4'd5,
    ALU_SRL = 4'd6,
    ALU_SRA = 4'd7,
    ALU_OR  = 4'd8,
    ALU_AND = 4'd9
  } alu_op_e;

  typedef enum logic [1:0] {
    A_SEL_RS1  = 2'd0,
    A_SEL_PC   = 2'd1,
    A_SEL_ZERO = 2'd2
  } a_sel_e;

  localparam logic B_SEL_RS2 = 1'b0;
  localparam logic B_SEL_IMM = 1'b1;

  typedef enum logic [2:0] {
    KIND_ALU    = 3'd0,
    KIND_LOAD   = 3'd1,
    KIND_STORE  = 3'd2,
    KIND_BRANCH = 3'd3,
    KIND_JAL    = 3'd4,
    KIND_JALR   = 3'd5,
    KIND_SYSTEM = 3'd6
  } kind_e;

  typedef struct packed {
    alu_op_e             alu_op;
    a_sel_e              a_sel;
    logic                b_sel;
    logic [XLEN-1:0]     imm;
    logic [REG_BITS-1:0] rs1;
    logic [REG_BITS-1:0] rs2;
    logic [REG_BITS-1:0] rd;
    logic                rd_we;
    kind_e               kind;
    logic [2:0]          funct3;
    logic [XLEN-1:0]     pc;
    logic                illegal;
  } decode_t;

  // funct3 -> ALU op for OP/OP-IMM; alt selects SUB (funct3=000) or SRA (funct3=101)
  function automatic alu_op_e alu_op_of(input logic [2:0] funct3, input logic alt);
    case (funct3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_LT;
      3'b011:  return ALU_LTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/alu_decode_stage_imm_gen.sv
// Immediate generator: sign-extended I/S/B/U/J immediate selected by the opcode.
module alu_decode_stage_imm_gen
  import alu_decode_stage_pkg::*;
(
  input  logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] imm_c
);

  always_comb begin
    imm_c = '0;
    case (instr[6:0])
      OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_MISC_MEM, OPC_SYSTEM:
        imm_c = {{(XLEN-12){instr[31]}}, instr[31:20]};
      OPC_STORE:
        imm_c = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
      OPC_BRANCH:
        imm_c = {{(XLEN-12){instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      OPC_LUI, OPC_AUIPC:
        imm_c = {instr[31:12], 12'h000};
      OPC_JAL:
        imm_c = {{(XLEN-20){instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm_c = '0;
    endcase
  end

endmodule

// File: rtl/alu_decode_stage.sv
// RV32E decode stage: decodes a fetched instruction into the ALU control bundle and
// holds it in a single-entry valid/ready pipeline register.
module alu_decode_stage
  import alu_decode_stage_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [XLEN-1:0]     in_instr,
  input  logic [XLEN-1:0]     in_pc,
  input  logic                flush,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [3:0]          out_alu_op,
  output logic [1:0]          out_a_sel,
  output logic                out_b_sel,
  output logic [XLEN-1:0]     out_imm,
  output logic [REG_BITS-1:0] out_rs1,
  output logic [REG_BITS-1:0] out_rs2,
  output logic [REG_BITS-1:0] out_rd,
  output logic                out_rd_we,
  output logic [2:0]          out_kind,
  output logic [2:0]          out_funct3,
  output logic [XLEN-1:0]     out_pc,
  output logic                out_illegal
);

  logic [XLEN-1:0] imm_c;
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [4:0]      rd_f, rs1_f, rs2_f;
  logic            ok, use_rd, use_rs1, use_rs2;
  logic            accept;
  logic            valid_q;
  decode_t         dec_c;
  decode_t         bundle_q;

  alu_decode_stage_imm_gen u_imm_gen (
    .instr (in_instr),
    .imm_c (imm_c)
  );

  assign opcode = in_instr[6:0];
  assign funct3 = in_instr[14:12];
  assign funct7 = in_instr[31:25];
  assign rd_f   = in_instr[11:7];
  assign rs1_f  = in_instr[19:15];
  assign rs2_f  = in_instr[24:20];

  // Opcode/funct decode; illegal encodings collapse to an ADD/system bundle
  always_comb begin
    dec_c        = '0;
    dec_c.alu_op = ALU_ADD;
    dec_c.a_sel  = A_SEL_RS1;
    dec_c.b_sel  = B_SEL_RS2;
    dec_c.kind   = KIND_SYSTEM;
    dec_c.imm    = imm_c;
    dec_c.rs1    = rs1_f[REG_BITS-1:0];
    dec_c.rs2    = rs2_f[REG_BITS-1:0];
    dec_c.rd     = rd_f[REG_BITS-1:0];
    dec_c.funct3 = funct3;
    dec_c.pc     = in_pc;
    ok      = 1'b1;
    use_rd  = 1'b0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    case (opcode)
      OPC_LUI: begin
        dec_c.a_sel = A_SEL_ZERO;
        dec_c.b_sel = B_SEL_IMM;
        dec_c.kind  = KIND_ALU;
        use_rd      = 1'b1;
      end
      OPC_AUIPC: begin
        dec_c.a_sel = A_SEL_PC;
        dec_c.b_sel = B_SEL_IMM;
        dec_c.kind  = KIND_ALU;
        use_rd      = 1'b1;
      end
      OPC_JAL: begin
        dec_c.a_sel = A_SEL_PC;
        dec_c.b_sel = B_SEL_IMM;
        dec_c.kind  = KIND_JAL;
        use_rd      = 1'b1;
      end
      OPC_JALR: begin
        dec_c.b_sel = B_SEL_IMM;
        dec_c.kind  = KIND_JALR;
        use_rd      = 1'b1;
        use_rs1     = 1'b1;
        ok          = (funct3 == 3'b000);
      end
      OPC_BRANCH: begin
        dec_c.kind = KIND_BRANCH;
        use_rs1    = 1'b1;
        use_rs2    = 1'b1;
        case (funct3[2:1])
          2'b00:   dec_c.alu_op = ALU_SUB;
          2'b10:   dec_c.alu_op = ALU_LT;
          2'b11:   dec_c.alu_op = ALU_LTU;
          default: ok = 1'b0;
        endcase
      end
      OPC_LOAD: begin
        dec_c.b_sel = B_SEL_IMM;
        dec_c.kind  = KIND_LOAD;
        use_rd      = 1'b1;
        use_rs1     = 1'b1;
        ok          = (funct3 != 3'b011) && (funct3 != 3'b110) && (funct3 != 3'b111);
      end
      OPC_STORE: begin
        dec_c.b_sel = B_SEL_IMM;
        dec_c.kind  = KIND_STORE;
        use_rs1     = 1'b1;
        use_rs2     = 1'b1;
        ok          = (funct3 <= 3'b010);
      end
      OPC_OP_IMM: begin
        dec_c.b_sel  = B_SEL_IMM;
        dec_c.kind   = KIND_ALU;
        dec_c.alu_op = alu_op_of(funct3, (funct3 == 3'b101) && funct7[5]);
        use_rd       = 1'b1;
        use_rs1      = 1'b1;
        if (funct3 == 3'b001) ok = (funct7 == FUNCT7_BASE);
        if (funct3 == 3'b101) ok = (funct7 == FUNCT7_BASE) || (funct7 == FUNCT7_ALT);
      end
      OPC_OP: begin
        dec_c.kind   = KIND_ALU;
        dec_c.alu_op = alu_op_of(funct3, funct7[5]);
        use_rd       = 1'b1;
        use_rs1      = 1'b1;
        use_rs2      = 1'b1;
        ok = (funct7 == FUNCT7_BASE) ||
             ((funct7 == FUNCT7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
      end
      OPC_MISC_MEM, OPC_SYSTEM: dec_c.kind = KIND_SYSTEM;
      default: ok = 1'b0;
    endcase
    // RV32E has only x0..x15: bit 4 of any used register field is illegal
    dec_c.illegal = !ok || (use_rd && rd_f[4]) || (use_rs1 && rs1_f[4]) || (use_rs2 && rs2_f[4]);
    dec_c.rd_we   = use_rd && (rd_f != 5'd0) && !dec_c.illegal;
    if (dec_c.illegal) begin
      dec_c.alu_op = ALU_ADD;
      dec_c.kind   = KIND_SYSTEM;
    end
  end

  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  // Single-entry pipeline register; flush wins over a same-cycle accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= 1'b0;
      bundle_q <= '0;
    end else begin
      if (flush)          valid_q <= 1'b0;
      else if (accept)    valid_q <= 1'b1;
      else if (out_ready) valid_q <= 1'b0;
      if (accept && !flush) bundle_q <= dec_c;
    end
  end

  assign out_valid   = valid_q;
  assign out_alu_op  = bundle_q.alu_op;
  assign out_a_sel   = bundle_q.a_sel;
  assign out_b_sel   = bundle_q.b_sel;
  assign out_imm     = bundle_q.imm;
  assign out_rs1     = bundle_q.rs1;
  assign out_rs2     = bundle_q.rs2;
  assign out_rd      = bundle_q.rd;
  assign out_rd_we   = bundle_q.rd_we;
  assign out_kind    = bundle_q.kind;
  assign out_funct3  = bundle_q.funct3;
  assign out_pc      = bundle_q.pc;
  assign out_illegal = bundle_q.illegal;

endmodule

// File: tb/tb_alu_decode_stage.sv
// Randomized self-checking bench for alu_decode_stage against an arithmetic decode model
// and a one-entry handshake model.
module tb_alu_decode_stage;
  import alu_decode_stage_pkg::*;

  logic        clk, rst_n;
  logic        in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0] in_instr, in_pc;
  logic [3:0]  out_alu_op;
  logic [1:0]  out_a_sel;
  logic        out_b_sel, out_rd_we, out_illegal;
  logic [31:0] out_imm, out_pc;
  logic [3:0]  out_rs1, out_rs2, out_rd;
  logic [2:0]  out_kind, out_funct3;

  int n_checks = 0;
  int n_errors = 0;

  logic        exp_valid;
  logic [31:0] exp_instr, exp_pc;
  logic [31:0] pc_ctr;

  typedef struct {
    logic [3:0]  op;
    logic [1:0]  a;
    logic        b;
    logic [31:0] imm;
    logic        we;
    logic [2:0]  kind;
    logic        ill;
    bit          chk_ab;
    bit          chk_imm;
  } exp_t;

  alu_decode_stage dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_alu_op(out_alu_op), .out_a_sel(out_a_sel), .out_b_sel(out_b_sel),
    .out_imm(out_imm), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
    .out_rd_we(out_rd_we), .out_kind(out_kind), .out_funct3(out_funct3),
    .out_pc(out_pc), .out_illegal(out_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference decode built from the instruction-set rules with plain arithmetic
  function automatic exp_t model(input logic [31:0] w);
    exp_t e;
    logic [6:0] f7;
    logic [2:0] f3;
    logic [4:0] rd, rs1, rs2;
    bit ok, urd, urs1, urs2, alt;
    int imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [3:0] tbl [8];
    tbl = '{ALU_ADD, ALU_SLL, ALU_LT, ALU_LTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
    f7 = w[31:25]; f3 = w[14:12]; rd = w[11:7]; rs1 = w[19:15]; rs2 = w[24:20];
    imm_i = int'(w[31:20]) - (w[31] ? 4096 : 0);
    imm_s = int'({w[31:25], w[11:7]}) - (w[31] ? 4096 : 0);
    imm_b = int'({w[31], w[7], w[30:25], w[11:8], 1'b0}) - (w[31] ? 8192 : 0);
    imm_u = int'({w[31:12], 12'h000});
    imm_j = int'({w[31], w[19:12], w[20], w[30:21], 1'b0}) - (w[31] ? 2097152 : 0);
    e = '{op: ALU_ADD, a: A_SEL_RS1, b: 1'b0, imm: 32'h0, we: 1'b0, kind: KIND_SYSTEM,
          ill: 1'b0, chk_ab: 1'b1, chk_imm: 1'b1};
    ok = 1; urd = 0; urs1 = 0; urs2 = 0;
    case (w[6:0])
      7'h37: begin e.a = A_SEL_ZERO; e.b = 1; e.imm = 32'(imm_u); e.kind = KIND_ALU; urd = 1; end
      7'h17: begin e.a = A_SEL_PC; e.b = 1; e.imm = 32'(imm_u); e.kind = KIND_ALU; urd = 1; end
      7'h6f: begin e.a = A_SEL_PC; e.b = 1; e.imm = 32'(imm_j); e.kind = KIND_JAL; urd = 1; end
      7'h67: begin e.b = 1; e.imm = 32'(imm_i); e.kind = KIND_JALR; urd = 1; urs1 = 1; ok = (f3 == 0); end
      7'h63: begin
        e.imm = 32'(imm_b); e.kind = KIND_BRANCH; urs1 = 1; urs2 = 1;
        ok = (f3 != 2) && (f3 != 3);
        e.op = (f3 < 2) ? ALU_SUB : (f3 < 6) ? ALU_LT : ALU_LTU;
      end
      7'h03: begin
        e.b = 1; e.imm = 32'(imm_i); e.kind = KIND_LOAD; urd = 1; urs1 = 1;
        ok = (f3 == 0) || (f3 == 1) || (f3 == 2) || (f3 == 4) || (f3 == 5);
      end
      7'h23: begin e.b = 1; e.imm = 32'(imm_s); e.kind = KIND_STORE; urs1 = 1; urs2 = 1; ok = (f3 < 3); end
      7'h13: begin
        e.b = 1; e.imm = 32'(imm_i); e.kind = KIND_ALU; urd = 1; urs1 = 1;
        alt = (f3 == 5) && (f7 == 7'h20);
        e.op = alt ? ALU_SRA : tbl[f3];
        if (f3 == 1) ok = (f7 == 0);
        if (f3 == 5) ok = (f7 == 0) || (f7 == 7'h20);
      end
      7'h33: begin
        e.kind = KIND_ALU; urd = 1; urs1 = 1; urs2 = 1; e.chk_imm = 0;
        alt = (f7 == 7'h20);
        ok = (f7 == 0) || (alt && (f3 == 0 || f3 == 5));
        e.op = (alt && f3 == 0) ? ALU_SUB : (alt && f3 == 5) ? ALU_SRA : tbl[f3];
      end
      7'h0f, 7'h73: begin e.chk_ab = 0; e.chk_imm = 0; end
      default: ok = 0;
    endcase
    e.ill = !ok || (urd && rd > 15) || (urs1 && rs1 > 15) || (urs2 && rs2 > 15);
    e.we  = urd && (rd != 0) && !e.ill;
    if (e.ill) begin e.op = ALU_ADD; e.kind = KIND_SYSTEM; e.chk_ab = 0; e.chk_imm = 0; end
    return e;
  endfunction

  function automatic logic [31:0] rand_legal();
    logic [31:0] r;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    int k;
    r = $urandom;
    rd = 5'($urandom_range(0, 15)); rs1 = 5'($urandom_range(0, 15)); rs2 = 5'($urandom_range(0, 15));
    f3 = 3'($urandom_range(0, 7));
    case ($urandom_range(0, 8))
      0: return {r[31:12], rd, 7'h37};
      1: return {r[31:12], rd, 7'h17};
      2: return {r[31:12], rd, 7'h6f};
      3: return {r[31:20], rs1, 3'b000, rd, 7'h67};
      4: begin k = $urandom_range(0, 5); f3 = 3'((k < 2) ? k : k + 2);
               return {r[31:25], rs2, rs1, f3, r[11:7], 7'h63}; end
      5: begin k = $urandom_range(0, 4); f3 = 3'((k < 3) ? k : k + 1);
               return {r[31:20], rs1, f3, rd, 7'h03}; end
      6: begin f3 = 3'($urandom_range(0, 2)); return {r[31:25], rs2, rs1, f3, r[11:7], 7'h23}; end
      7: begin
        f7 = (f3 == 5 && r[0]) ? 7'h20 : 7'h00;
        if (f3 == 1 || f3 == 5) return {f7, r[24:20], rs1, f3, rd, 7'h13};
        return {r[31:20], rs1, f3, rd, 7'h13};
      end
      default: begin
        f7 = ((f3 == 0 || f3 == 5) && r[0]) ? 7'h20 : 7'h00;
        return {f7, rs2, rs1, f3, rd, 7'h33};
      end
    endcase
  endfunction

  function automatic logic [31:0] rand_any();
    logic [31:0] r;
    logic [6:0]  opcs [12];
    opcs = '{7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0f, 7'h73, 7'h2b};
    r = $urandom;
    case ($urandom_range(0, 3))
      0, 1: return rand_legal();
      2: return {r[31:7], opcs[$urandom_range(0, 11)]};
      default: return r;
    endcase
  endfunction

  task automatic compare_bundle();
    exp_t e;
    e = model(exp_instr);
    check("pc", out_pc, exp_pc);
    check("funct3", 32'(out_funct3), 32'(exp_instr[14:12]));
    check("rs1", 32'(out_rs1), 32'(exp_instr[18:15]));
    check("rs2", 32'(out_rs2), 32'(exp_instr[23:20]));
    check("rd", 32'(out_rd), 32'(exp_instr[10:7]));
    check("illegal", 32'(out_illegal), 32'(e.ill));
    check("rd_we", 32'(out_rd_we), 32'(e.we));
    check("kind", 32'(out_kind), 32'(e.kind));
    check("alu_op", 32'(out_alu_op), 32'(e.op));
    if (e.chk_ab) begin
      check("a_sel", 32'(out_a_sel), 32'(e.a));
      check("b_sel", 32'(out_b_sel), 32'(e.b));
    end
    if (e.chk_imm) check("imm", out_imm, e.imm);
  endtask

  // One clock: drive after negedge, sample 1ns later, advance the handshake model
  task automatic step(input logic iv, input logic [31:0] w, input logic ordy, input logic fl);
    logic acc;
    in_valid = iv; in_instr = w; in_pc = pc_ctr; out_ready = ordy; flush = fl;
    #1;
    check("out_valid", 32'(out_valid), 32'(exp_valid));
    check("in_ready", 32'(in_ready), 32'(!exp_valid || ordy));
    if (exp_valid) compare_bundle();
    acc = iv && (!exp_valid || ordy);
    if (fl) exp_valid = 1'b0;
    else if (acc) begin exp_valid = 1'b1; exp_instr = w; exp_pc = pc_ctr; end
    else if (ordy) exp_valid = 1'b0;
    if (acc) pc_ctr = pc_ctr + 32'd4;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic directed(input logic [31:0] w, input logic [3:0] op, input logic [2:0] kind,
                          input logic ill, input logic we, input logic [31:0] imm, input bit chk_imm);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b1, w, 1'b1, 1'b0);
    check("dir_alu_op", 32'(out_alu_op), 32'(op));
    check("dir_kind", 32'(out_kind), 32'(kind));
    check("dir_illegal", 32'(out_illegal), 32'(ill));
    check("dir_rd_we", 32'(out_rd_we), 32'(we));
    if (chk_imm) check("dir_imm", out_imm, imm);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; flush = 1'b0; out_ready = 1'b0;
    exp_valid = 1'b0; exp_instr = '0; exp_pc = '0; pc_ctr = 32'h1000;
    @(negedge clk); @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_in_ready", 32'(in_ready), 32'h1);
    check("rst_imm", out_imm, 32'h0);
    check("rst_pc", out_pc, 32'h0);
    check("rst_ctrl", 32'({out_alu_op, out_a_sel, out_b_sel, out_rd_we, out_kind, out_illegal}), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    directed(32'h00500093, ALU_ADD, KIND_ALU, 1'b0, 1'b1, 32'd5, 1'b1);
    check("addi_rd", 32'(out_rd), 32'd1);
    check("addi_bsel", 32'(out_b_sel), 32'(B_SEL_IMM));
    directed(32'h402081B3, ALU_SUB, KIND_ALU, 1'b0, 1'b1, 32'h0, 1'b0);
    check("sub_regs", 32'({out_rs1, out_rs2, out_rd}), 32'h123);
    check("sub_bsel", 32'(out_b_sel), 32'(B_SEL_RS2));
    directed(32'h40335293, ALU_SRA, KIND_ALU, 1'b0, 1'b1, 32'h403, 1'b1);
    directed(32'h00000833, ALU_ADD, KIND_SYSTEM, 1'b1, 1'b0, 32'h0, 1'b0);
    directed(32'hFE208EE3, ALU_SUB, KIND_BRANCH, 1'b0, 1'b0, 32'hFFFFFFFC, 1'b1);
    step(1'b0, 32'h0, 1'b1, 1'b0);

    // Random traffic with backpressure and occasional flushes
    for (int i = 0; i < 600; i++)
      step(1'($urandom_range(0, 9) < 7), rand_any(), 1'($urandom_range(0, 9) < 7),
           1'($urandom_range(0, 19) == 0));

    // Backpressure: entry held for 5 cycles, then the next instruction follows
    step(1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b1, 32'h00A00113, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 32'h00B00193, 1'b0, 1'b0);
    step(1'b1, 32'h00B00193, 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0);

    // Flush beats a simultaneous accept
    step(1'b1, 32'h00C00213, 1'b1, 1'b0);
    step(1'b1, 32'h00D00293, 1'b1, 1'b1);
    step(1'b0, 32'h0, 1'b1, 1'b0);

    // Asynchronous reset while an entry is held
    for (int i = 0; i < 4; i++) step(1'b1, rand_legal(), 1'b1, 1'b0);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(out_valid), 32'h0);
    check("async_rst_pc", out_pc, 32'h0);
    check("async_rst_ready", 32'(in_ready), 32'h1);
    exp_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Back-to-back legal stream at full rate
    for (int i = 0; i < 100; i++) step(1'b1, rand_legal(), 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
